// File: rtl/sd_wb_sequencer.sv
// sd_wb_sequencer: runs one SD command job on a Wishbone host controller
// (write argument, write command, poll status, read 128-bit response).
// Optional per-bus-cycle ack timeout: define SD_WB_SEQ_TIMEOUT_EN.
module sd_wb_sequencer #(
    parameter logic [4:0]  ADR_ARG     = 5'h02,
    parameter logic [4:0]  ADR_CMD     = 5'h03,
    parameter logic [4:0]  ADR_STAT    = 5'h04,
    parameter logic [4:0]  ADR_RESP    = 5'h05,
    parameter int unsigned POLL_MAX    = 16,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    output logic         busy,
    output logic         done,
    output logic [1:0]   err_code,
    output logic [127:0] resp,
    output logic         wb_we_o,
    output logic [4:0]   wb_adr_o,
    output logic         wb_stb_o,
    output logic [127:0] wb_dat_o,
    input  logic [127:0] wb_dat_i,
    input  logic         wb_ack_i,
    input  logic         wb_err_i
);

    localparam int unsigned   PW        = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ARG, S_WR_CMD, S_POLL, S_RD_RESP, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_BUS  = 2'b01,
        ERR_TMO  = 2'b10,
        ERR_POLL = 2'b11
    } err_e;

    state_e         state_q, state_d;
    err_e           err_q, err_d;
    logic           stb_q, stb_d;
    logic           we_q, we_d;
    logic [4:0]     adr_q, adr_d;
    logic [127:0]   dat_q, dat_d;
    logic [127:0]   resp_q, resp_d;
    logic [5:0]     index_q, index_d;
    logic [31:0]    arg_q, arg_d;
    logic [PW-1:0]  poll_q, poll_d;

    logic bus_err;
    logic bus_ack;
    logic tmo_hit;
    logic cycle_end;

    // A simultaneous ack and err is treated as an error.
    assign bus_err   = stb_q & wb_err_i;
    assign bus_ack   = stb_q & wb_ack_i & ~wb_err_i;
    assign cycle_end = bus_err | bus_ack | tmo_hit;

`ifdef SD_WB_SEQ_TIMEOUT_EN
    localparam int unsigned   TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    logic [TW-1:0] tmo_q, tmo_d;

    assign tmo_hit = stb_q & ~wb_ack_i & ~wb_err_i & (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d = '0;
        if (stb_q && stb_d) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // NOTE: reset is synchronous and active-low; every flop uses <= so all
    // registers sample the same pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            err_q   <= ERR_OK;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            resp_q  <= '0;
            index_q <= '0;
            arg_q   <= '0;
            poll_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            resp_q  <= resp_d;
            index_q <= index_d;
            arg_q   <= arg_d;
            poll_q  <= poll_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR_ARG;
                end
            end
            S_WR_ARG: begin
                if (bus_err || tmo_hit) begin
                    state_d = S_DONE;
                end else if (bus_ack) begin
                    state_d = S_WR_CMD;
                end
            end
            S_WR_CMD: begin
                if (bus_err || tmo_hit) begin
                    state_d = S_DONE;
                end else if (bus_ack) begin
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                if (bus_err || tmo_hit) begin
                    state_d = S_DONE;
                end else if (bus_ack) begin
                    if (wb_dat_i[0]) begin
                        state_d = S_RD_RESP;
                    end else if (poll_q == POLL_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RD_RESP: begin
                if (cycle_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a variable unassigned and no latch appears.
    always_comb begin
        index_d = index_q;
        arg_d   = arg_q;
        resp_d  = resp_q;
        err_d   = err_q;
        poll_d  = poll_q;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        adr_d   = '0;
        dat_d   = '0;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);

        if (state_q == S_IDLE && start) begin
            index_d = cmd_index;
            arg_d   = cmd_arg;
            resp_d  = '0;
            err_d   = ERR_OK;
            poll_d  = '0;
        end

        if (bus_err) begin
            err_d = ERR_BUS;
        end else if (tmo_hit) begin
            err_d = ERR_TMO;
        end else if (bus_ack) begin
            if (state_q == S_POLL && !wb_dat_i[0]) begin
                poll_d = poll_q + PW'(1);
                if (poll_q == POLL_LAST) begin
                    err_d = ERR_POLL;
                end
            end
            if (state_q == S_RD_RESP) begin
                resp_d = wb_dat_i;
            end
        end

        // A finished bus cycle always leaves one stb-low cycle before the next.
        if (state_d inside {S_WR_ARG, S_WR_CMD, S_POLL, S_RD_RESP} &&
            (!stb_q || !cycle_end)) begin
            stb_d = 1'b1;
            unique case (state_d)
                S_WR_ARG: begin
                    we_d  = 1'b1;
                    adr_d = ADR_ARG;
                    dat_d = {96'b0, arg_d};
                end
                S_WR_CMD: begin
                    we_d  = 1'b1;
                    adr_d = ADR_CMD;
                    dat_d = {122'b0, index_d};
                end
                S_POLL: begin
                    adr_d = ADR_STAT;
                end
                S_RD_RESP: begin
                    adr_d = ADR_RESP;
                end
                default: begin
                    stb_d = 1'b0;
                end
            endcase
        end
    end

    assign err_code = err_q;
    assign resp     = resp_q;
    assign wb_stb_o = stb_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_sd_wb_sequencer.sv
// tb_sd_wb_sequencer: randomized jobs against a reactive Wishbone slave; the
// expected bus transaction list and result are built from the job description.
module tb_sd_wb_sequencer;

    localparam int         POLL_MAX    = 4;
    localparam int         ACK_TIMEOUT = 8;
    localparam logic [4:0] A_ARG  = 5'h02;
    localparam logic [4:0] A_CMD  = 5'h03;
    localparam logic [4:0] A_STAT = 5'h04;
    localparam logic [4:0] A_RESP = 5'h05;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_arg = '0;
    logic         busy, done, wb_we_o, wb_stb_o;
    logic [1:0]   err_code;
    logic [127:0] resp, wb_dat_o;
    logic [4:0]   wb_adr_o;
    logic [127:0] wb_dat_i = '0;
    logic         wb_ack_i = 1'b0;
    logic         wb_err_i = 1'b0;

    always #5 clock = ~clock;

    sd_wb_sequencer #(
        .POLL_MAX    (POLL_MAX),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code),
        .resp      (resp),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_stb_o  (wb_stb_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Slave behaviour for the current job and the observed bus transactions.
    int           sl_fail_n = 0;
    int           sl_err_at = -1;
    bit           sl_err_ack = 1'b0;
    bit           sl_no_ack = 1'b0;
    int           sl_lat_max = 1;
    logic [127:0] sl_resp_val = '0;
    int           sl_bus_idx = 0;
    int           sl_stat_reads = 0;
    logic [5:0]   obs_ctl[$];
    logic [127:0] obs_dat[$];
    logic [5:0]   exp_ctl[$];
    logic [127:0] exp_dat[$];

    initial begin : slave
        int wait_n = 0;
        int lat = 1;
        bit responded = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (responded) begin
                responded = 1'b0;
                wb_ack_i  = 1'b0;
                wb_err_i  = 1'b0;
                wb_dat_i  = '0;
                wait_n    = 0;
                check("stb_drop", 128'(wb_stb_o), 128'(0));
            end else if (wb_stb_o) begin
                wait_n++;
                if (!sl_no_ack && wait_n >= lat) begin
                    obs_ctl.push_back({wb_we_o, wb_adr_o});
                    obs_dat.push_back(wb_dat_o);
                    if (sl_bus_idx == sl_err_at) begin
                        wb_err_i = 1'b1;
                        wb_ack_i = sl_err_ack;
                        wb_dat_i = rnd128();
                    end else begin
                        wb_ack_i = 1'b1;
                        if (wb_adr_o == A_STAT) begin
                            wb_dat_i    = rnd128();
                            wb_dat_i[0] = (sl_stat_reads >= sl_fail_n);
                            sl_stat_reads++;
                        end else if (wb_adr_o == A_RESP) begin
                            wb_dat_i = sl_resp_val;
                        end else begin
                            wb_dat_i = rnd128();
                        end
                    end
                    sl_bus_idx++;
                    responded = 1'b1;
                    lat = int'($urandom_range(sl_lat_max, 1));
                end
            end else begin
                wait_n = 0;
            end
        end
    end

    // Expected transaction list and result, straight from the job rules.
    task automatic build_model(input logic [5:0] idx, input logic [31:0] arg, input int fail_n,
                               input int err_at, input logic [127:0] rv,
                               output logic [1:0] e_err, output logic [127:0] e_resp);
        bit ok = 1'b0;
        exp_ctl.delete();
        exp_dat.delete();
        exp_ctl.push_back({1'b1, A_ARG});
        exp_dat.push_back({96'b0, arg});
        exp_ctl.push_back({1'b1, A_CMD});
        exp_dat.push_back({122'b0, idx});
        for (int i = 0; i < POLL_MAX && !ok; i++) begin
            exp_ctl.push_back({1'b0, A_STAT});
            exp_dat.push_back('0);
            if (i >= fail_n) begin
                exp_ctl.push_back({1'b0, A_RESP});
                exp_dat.push_back('0);
                ok = 1'b1;
            end
        end
        e_err  = ok ? 2'b00 : 2'b11;
        e_resp = ok ? rv : '0;
        if (err_at >= 0 && err_at < exp_ctl.size()) begin
            while (exp_ctl.size() > err_at + 1) begin
                void'(exp_ctl.pop_back());
                void'(exp_dat.pop_back());
            end
            e_err  = 2'b01;
            e_resp = '0;
        end
    endtask

    task automatic set_slave(input int fail_n, input int err_at, input bit err_ack,
                             input int lat_max, input logic [127:0] rv, input bit no_ack);
        sl_fail_n     = fail_n;
        sl_err_at     = err_at;
        sl_err_ack    = err_ack;
        sl_lat_max    = lat_max;
        sl_resp_val   = rv;
        sl_no_ack     = no_ack;
        sl_bus_idx    = 0;
        sl_stat_reads = 0;
        obs_ctl.delete();
        obs_dat.delete();
    endtask

    task automatic pulse_start(input logic [5:0] idx, input logic [31:0] arg);
        @(negedge clock);
        start     = 1'b1;
        cmd_index = idx;
        cmd_arg   = arg;
        @(negedge clock);
        start     = 1'b0;
        cmd_index = 6'($urandom());
        cmd_arg   = $urandom();
    endtask

    task automatic apply_reset(input string name);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check({name, ":stb"}, 128'(wb_stb_o), 128'(0));
        check({name, ":busy"}, 128'(busy), 128'(0));
        check({name, ":done"}, 128'(done), 128'(0));
        check({name, ":err"}, 128'(err_code), 128'(0));
        check({name, ":resp"}, resp, 128'(0));
        check({name, ":bus"}, {wb_dat_o, wb_adr_o, wb_we_o}, 134'(0));
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_job(input string name, input logic [5:0] idx, input logic [31:0] arg,
                           input int fail_n, input int err_at, input bit err_ack,
                           input int lat_max, input logic [127:0] rv, input bit noise);
        logic [1:0]   e_err;
        logic [127:0] e_resp;
        int done_n = 0;
        int cyc = 0;
        bit seen = 1'b0;
        build_model(idx, arg, fail_n, err_at, rv, e_err, e_resp);
        set_slave(fail_n, err_at, err_ack, lat_max, rv, 1'b0);
        pulse_start(idx, arg);
        check({name, ":busy"}, 128'(busy), 128'(1));
        check({name, ":err_clr"}, 128'(err_code), 128'(0));
        while (!seen && cyc < 2000) begin
            if (done) begin
                seen = 1'b1;
                done_n++;
                check({name, ":err_code"}, 128'(err_code), 128'(e_err));
                check({name, ":resp"}, resp, e_resp);
            end else begin
                start = noise && !start && ($urandom_range(7, 0) == 0);
                @(negedge clock);
                cyc++;
            end
        end
        start = 1'b0;
        check({name, ":done_seen"}, 128'(seen), 128'(1));
        if (!seen) begin
            apply_reset({name, ":recover"});
        end else begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                if (done) done_n++;
            end
            check({name, ":done_once"}, 128'(done_n), 128'(1));
            check({name, ":busy_idle"}, 128'(busy), 128'(0));
            check({name, ":err_hold"}, 128'(err_code), 128'(e_err));
            check({name, ":n_txn"}, 128'(obs_ctl.size()), 128'(exp_ctl.size()));
            for (int i = 0; i < obs_ctl.size() && i < exp_ctl.size(); i++) begin
                check($sformatf("%s:ctl%0d", name, i), 128'(obs_ctl[i]), 128'(exp_ctl[i]));
                if (exp_ctl[i][5]) begin
                    check($sformatf("%s:dat%0d", name, i), obs_dat[i], exp_dat[i]);
                end
            end
        end
    endtask

    task automatic run_hang();
        int hi = 0;
        bit seen = 1'b0;
        set_slave(0, -1, 1'b0, 1, '0, 1'b1);
        pulse_start(6'd9, 32'hDEAD_BEEF);
        for (int c = 0; c < 100 && !seen; c++) begin
            if (done) begin
                seen = 1'b1;
                check("tmo:err_code", 128'(err_code), 128'(2'b10));
            end else begin
                if (wb_stb_o) hi++;
                @(negedge clock);
            end
        end
`ifdef SD_WB_SEQ_TIMEOUT_EN
        check("tmo:done_seen", 128'(seen), 128'(1));
        check("tmo:stb_cycles", 128'(hi), 128'(ACK_TIMEOUT));
        check("tmo:no_txn", 128'(obs_ctl.size()), 128'(0));
        @(negedge clock);
        check("tmo:busy_idle", 128'(busy), 128'(0));
        check("tmo:stb_idle", 128'(wb_stb_o), 128'(0));
`else
        check("hang:no_done", 128'(seen), 128'(0));
        check("hang:stb_high", 128'(wb_stb_o), 128'(1));
        check("hang:adr", 128'(wb_adr_o), 128'(A_ARG));
        apply_reset("hang_rst");
`endif
        sl_no_ack = 1'b0;
    endtask

    task automatic run_reset_in_poll();
        bit found = 1'b0;
        int done_n = 0;
        set_slave(1000, -1, 1'b0, 3, '0, 1'b0);
        pulse_start(6'd17, 32'h0BAD_F00D);
        for (int c = 0; c < 200 && !found; c++) begin
            if (wb_stb_o && !wb_we_o && wb_adr_o == A_STAT) begin
                found = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        check("rst_poll:reached", 128'(found), 128'(1));
        reset = 1'b0;
        @(negedge clock);
        check("rst_poll:stb", 128'(wb_stb_o), 128'(0));
        check("rst_poll:busy", 128'(busy), 128'(0));
        check("rst_poll:err", 128'(err_code), 128'(0));
        if (done) done_n++;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (done) done_n++;
        end
        check("rst_poll:no_done", 128'(done_n), 128'(0));
        check("rst_poll:idle_stb", 128'(wb_stb_o), 128'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        apply_reset("reset");
        run_job("normal", 6'd7, 32'h1234, 0, -1, 1'b0, 1, 128'hA5, 1'b0);
        run_job("poll3", 6'd12, 32'h5555_AAAA, 3, -1, 1'b0, 1, rnd128(), 1'b0);
        run_job("exhaust", 6'd55, 32'hFFFF_0001, 1000, -1, 1'b0, 2, rnd128(), 1'b0);
        run_job("err_cmd", 6'd8, 32'h0000_0777, 0, 1, 1'b0, 1, rnd128(), 1'b0);
        run_job("err_ack_cmd", 6'd41, 32'h8000_0000, 0, 1, 1'b1, 1, rnd128(), 1'b0);
        run_hang();
        run_reset_in_poll();
        run_job("after_rst", 6'd2, 32'hCAFE_0123, 1, -1, 1'b0, 2, rnd128(), 1'b0);
        for (int j = 0; j < 24; j++) begin
            int fail_n;
            int err_at;
            fail_n = int'($urandom_range(5, 0));
            err_at = -1;
            if ($urandom_range(2, 0) == 0) begin
                err_at = int'($urandom_range(6, 0));
            end
            run_job($sformatf("rand%0d", j), 6'($urandom()), $urandom(), fail_n, err_at,
                    1'($urandom_range(1, 0)), int'($urandom_range(3, 1)), rnd128(), 1'b1);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sd_wb_sequencer.md
SD_WB_SEQUENCER -- requirements
Module: sd_wb_sequencer

Interface
REQ-001 Parameter ADR_ARG, default 5'h02, Wishbone address of the argument register.
REQ-002 Parameter ADR_CMD, default 5'h03, Wishbone address of the command register.
REQ-003 Parameter ADR_STAT, default 5'h04, Wishbone address of the status register; bit 0 = command complete.
REQ-004 Parameter ADR_RESP, default 5'h05, Wishbone address of the 128-bit response register.
REQ-005 Parameter POLL_MAX, default 16, maximum number of status reads per job.
REQ-006 Parameter ACK_TIMEOUT, default 64, wb_clock cycles to wait for ack or error per bus cycle.
REQ-007 Ports:
- clock  in  1  single clock, same domain as the host Wishbone slave.
- reset  in  1  synchronous, active-low.
- start  in  1  job request pulse; sampled only in IDLE.
- cmd_index  in  6  SD command index.
- cmd_arg  in  32  SD command argument.
- busy  out  1  high from start acceptance until DONE exits.
- done  out  1  one-cycle completion pulse.
- err_code  out  2  00 ok, 01 bus error, 10 ack timeout, 11 poll exhausted; valid with done.
- resp  out  128  response captured in RD_RESP.
- wb_we_o  out  1  Wishbone write enable.
- wb_adr_o  out  5  Wishbone address.
- wb_stb_o  out  1  Wishbone strobe.
- wb_dat_o  out  128  Wishbone write data.
- wb_dat_i  in  128  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.

Function
REQ-008 FSM states: IDLE, WR_ARG, WR_CMD, POLL, RD_RESP, DONE.
REQ-009 IDLE and start=1: latch cmd_index/cmd_arg, clear resp, clear the poll counter, go to WR_ARG; busy=1 from the next cycle.
REQ-010 WR_ARG drives we=1, adr=ADR_ARG, dat={96'b0, arg}, stb=1; stays until ack or err.
REQ-011 WR_CMD drives we=1, adr=ADR_CMD, dat={122'b0, index}, stb=1.
REQ-012 POLL drives we=0, adr=ADR_STAT, stb=1.
- Ack with dat_i[0]=1: go to RD_RESP.
- Ack with dat_i[0]=0: increment the poll counter and issue a new read after one idle cycle (stb=0).
REQ-013 If the poll counter reaches POLL_MAX without completion, go to DONE with err_code=11.
REQ-014 RD_RESP drives we=0, adr=ADR_RESP, stb=1; on ack, capture wb_dat_i into resp and go to DONE with err_code=00.
REQ-015 A bus cycle ends on the first cycle with ack or err high; stb drops in the following cycle. Each bus cycle lasts at least one cycle.
REQ-016 ack and err high together in the same cycle count as err.
REQ-017 err in any bus state: go to DONE with err_code=01; resp keeps its current value.
REQ-018 DONE lasts one cycle: done=1, stb=0, busy=0 in the following IDLE.
REQ-019 start while busy is ignored and is not queued.
REQ-020 err_code holds its value until the next accepted start, which clears it to 00.

Reset
REQ-021 reset=0 on a rising clock edge forces:
- state IDLE;
- busy=0, done=0, err_code=00, resp=0;
- wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0;
- poll and timeout counters cleared.
REQ-022 Reset mid-transaction drops stb on the same edge; the job is discarded and done is not pulsed.

Configuration
REQ-023 With SD_WB_SEQ_TIMEOUT_EN defined:
- a per-bus-cycle counter runs while stb=1 and is cleared when stb falls;
- if it reaches ACK_TIMEOUT without ack or err, stb drops and the FSM goes to DONE with err_code=10.
REQ-024 Without SD_WB_SEQ_TIMEOUT_EN, the counter is absent, the FSM waits indefinitely for ack or err, and err_code=10 is never produced.

Verification
REQ-025 Normal job: start with index 7 and arg 32'h1234, slave acks each cycle in 1 cycle, status bit0=1 on the first poll, resp=128'hA5.
- Expected: writes to 02 and 03 in order, one read of 04, one read of 05.
- Expected: done pulse with err_code=00 and resp=128'hA5.
REQ-026 Polling: status bit0=0 for 3 reads, then 1 -> exactly 4 status reads, each separated by a stb-low cycle, then the response read.
REQ-027 Poll exhaustion: status never set, POLL_MAX=4 -> 4 reads, then done with err_code=11 and no read of 05.
REQ-028 Bus error: err asserted during WR_CMD, also with simultaneous ack -> done with err_code=01 and no further bus cycles.
REQ-029 Timeout (macro defined, ACK_TIMEOUT=8): no ack in WR_ARG -> stb drops after 8 cycles, done with err_code=10.
- Without the macro: stb is still high after 100 cycles.
REQ-030 Reset during POLL with stb high -> stb=0 and busy=0 on the next edge, no done pulse; a later start runs a full job normally.
